// File: rtl/range_ramp_sequencer_pkg.sv
// range_seq_pkg: shared register map, status/ctrl bit positions, FSM states and the ramp step helper
package range_seq_pkg;
  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STEP   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;
  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_CNT    = 4;
  localparam int ST_IRQ    = 8;
  localparam int CT_IRQ_EN = 0;
  localparam int CT_FLUSH  = 1;
  typedef enum logic [1:0] {IDLE, LOAD, RAMP, DONE} state_t;
  // one bounded step toward tgt; step 0 jumps, 9-bit distance so the move never overshoots or wraps
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt, input logic [7:0] step);
    logic [8:0] d, m;
    d = tgt >= cur ? {1'b0, tgt} - {1'b0, cur} : {1'b0, cur} - {1'b0, tgt};
    m = (step == 8'd0 || {1'b0, step} > d) ? d : {1'b0, step};
    return tgt >= cur ? cur + m[7:0] : cur - m[7:0];
  endfunction
endpackage

// File: rtl/range_ramp_sequencer_if.sv
// range_ramp_sequencer_if: Avalon-MM bus between the HPS bridge (master) and the sequencer (slave)
// Signals: avs_address[1:0], avs_write, avs_writedata[31:0], avs_read, avs_readdata[31:0], avs_waitrequest
interface range_ramp_sequencer_if;
  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  modport master (output avs_address, avs_write, avs_writedata, avs_read, input avs_readdata, avs_waitrequest);
  modport slave  (input avs_address, avs_write, avs_writedata, avs_read, output avs_readdata, avs_waitrequest);
endinterface

// File: rtl/range_ramp_sequencer_sync_fifo.sv
// sync_fifo: first-word-fall-through command queue, flush has priority over push/pop
// Ports: clk, reset (sync, active-high); i_push/i_pop/i_flush, i_din -> o_dout head entry;
//        o_full/o_empty/o_count occupancy. Pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd];
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_din;
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd  <= w_pop ? r_rd + AW'(1) : r_rd;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/range_ramp_sequencer.sv
// range_ramp_sequencer: queues HPS target pairs and ramps two 8-bit actuator ranges toward them, one step per tick
// Ports: clk, reset (sync, active-high); avs Avalon-MM slave (0 CMD, 1 STEP, 2 STATUS, 3 CTRL);
//        range1/range2 channel positions; irq = irq_pending & irq_en; busy = FSM active or queue non-empty
module range_ramp_sequencer
  import range_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV = 50000,
  parameter logic [7:0] DEFAULT_RANGE = 8'h80
) (
  input  logic clk,
  input  logic reset,
  range_ramp_sequencer_if.slave avs,
  output logic [7:0] range1,
  output logic [7:0] range2,
  output logic irq,
  output logic busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TICK_DIV);
  state_t r_state, w_next;
  logic [7:0] r_range1, r_range2, r_tgt1, r_tgt2, r_step;
  logic [TW-1:0] r_tick;
  logic r_irq_en, r_irq_pend, r_rd_done;
  logic [31:0] r_rdata;
  logic w_full, w_empty, w_wr, w_push, w_flush, w_pop, w_tick, w_arrive, w_set_irq, w_clr_irq, w_rd_first;
  logic [CW-1:0] w_count;
  logic [15:0] w_head;
  logic [7:0] w_nr1, w_nr2;
  logic [31:0] w_status, w_rmux;
  // reads stall one cycle for the registered data; CMD writes stall while the queue is full
  assign w_rd_first = avs.avs_read & ~r_rd_done;
  assign avs.avs_waitrequest = w_rd_first | (avs.avs_write & avs.avs_address == ADDR_CMD & w_full);
  assign avs.avs_readdata = r_rdata;
  assign w_wr      = avs.avs_write & ~avs.avs_waitrequest;
  assign w_push    = w_wr & avs.avs_address == ADDR_CMD;
  assign w_flush   = w_wr & avs.avs_address == ADDR_CTRL & avs.avs_writedata[CT_FLUSH];
  assign w_clr_irq = w_wr & avs.avs_address == ADDR_STATUS & avs.avs_writedata[ST_IRQ];
  assign w_pop     = r_state == LOAD;
  assign w_tick    = r_state == RAMP && r_tick == TW'(TICK_DIV - 1);
  assign w_nr1     = ramp_toward(r_range1, r_tgt1, r_step);
  assign w_nr2     = ramp_toward(r_range2, r_tgt2, r_step);
  assign w_arrive  = w_tick & w_nr1 == r_tgt1 & w_nr2 == r_tgt2;
  assign w_set_irq = r_state == DONE & w_empty & ~w_flush;
  assign busy      = r_state != IDLE | ~w_empty;
  assign irq       = r_irq_pend & r_irq_en;
  assign range1    = r_range1;
  assign range2    = r_range2;
  assign w_status  = {23'd0, r_irq_pend, 4'(w_count), 1'b0, w_empty, w_full, busy};
  assign w_rmux    = avs.avs_address == ADDR_STEP ? {24'd0, r_step}
                   : avs.avs_address == ADDR_STATUS ? w_status
                   : avs.avs_address == ADDR_CTRL ? {31'd0, r_irq_en}
                   : 32'd0;
  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (avs.avs_writedata[15:0]),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_comb begin
    w_next = w_flush ? IDLE
           : r_state == IDLE ? (w_empty ? IDLE : LOAD)
           : r_state == LOAD ? RAMP
           : r_state == RAMP ? (w_arrive ? DONE : RAMP)
           : IDLE;
  end
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_range1   <= DEFAULT_RANGE;
      r_range2   <= DEFAULT_RANGE;
      r_tgt1     <= DEFAULT_RANGE;
      r_tgt2     <= DEFAULT_RANGE;
      r_step     <= 8'd1;
      r_irq_en   <= 1'b0;
      r_irq_pend <= 1'b0;
      r_tick     <= '0;
      r_rd_done  <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rd_done  <= w_rd_first;
      r_rdata    <= w_rd_first ? w_rmux : r_rdata;
      r_step     <= w_wr && avs.avs_address == ADDR_STEP ? avs.avs_writedata[7:0] : r_step;
      r_irq_en   <= w_wr && avs.avs_address == ADDR_CTRL ? avs.avs_writedata[CT_IRQ_EN] : r_irq_en;
      r_irq_pend <= w_set_irq | (r_irq_pend & ~w_clr_irq);
      r_tick     <= r_state == RAMP && !w_tick ? r_tick + TW'(1) : '0;
      // a zero byte keeps that channel's previous target
      if (w_pop && !w_flush) begin
        r_tgt1 <= w_head[7:0] != 8'd0 ? w_head[7:0] : r_tgt1;
        r_tgt2 <= w_head[15:8] != 8'd0 ? w_head[15:8] : r_tgt2;
      end
      if (w_tick && !w_flush) begin
        r_range1 <= w_nr1;
        r_range2 <= w_nr2;
      end
    end
  end
endmodule
